// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width needed to count WIDTH compute cycles with headroom.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bi, bo = borrow out.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   // Difference bit and borrow generation for one bit position.
   always_comb begin
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~x & bi) | (y & bi);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first; optional signed overflow flag (SERIAL_SUB_OVF_EN).
// Latency: result valid WIDTH edges after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: result and flags held in DONE until out_ready; no new operands accepted meanwhile.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             borrow_q;
   logic [CNT_W-1:0] cnt;
   logic             cell_d;
   logic             cell_bo;

   full_subtractor u_cell (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .bi (borrow_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   // Control FSM and serial datapath. diff doubles as the result shift
   // register: it only moves during RUN, so it is stable in DONE and IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         a_sr       <= '0;
         b_sr       <= '0;
         diff       <= '0;
         borrow_q   <= 1'b0;
         borrow_out <= 1'b0;
         cnt        <= '0;
`ifdef SERIAL_SUB_OVF_EN
         overflow   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  borrow_q <= borrow_in;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr     <= a_sr >> 1;
               b_sr     <= b_sr >> 1;
               diff     <= {cell_d, diff[WIDTH-1:1]};
               borrow_q <= cell_bo;
               cnt      <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  // Last bit: the cell is looking at the operand MSBs and
                  // producing the result MSB, so the flags come for free.
                  borrow_out <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                  overflow   <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
`endif
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
